fp_divider_iter: RTL

- Parametrised, IP-free iterative IEEE-754 floating-point divider; successor to the vendor-IP float divide wrapper.
- Generic in exponent and mantissa width, and fully handles special operands.
- Uses a start/ready/valid handshake with output back-pressure and IEEE exception flags.
- Feeds the same float arithmetic datapath; the default configuration is single precision.

---
 rtl/fp_divider_iter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fp_divider_iter.sv
// fp_divider_iter: iterative restoring IEEE-754 divider; div_start/div_ready operand handshake, div_result/result_ready/result_accept output handshake, flag_dz/inv/ovf/unf exceptions
module fp_divider_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   div_start,
  output logic                   div_ready,
  input  logic [EXP_W+MAN_W:0]   dividend,
  input  logic [EXP_W+MAN_W:0]   divisor,
  output logic [EXP_W+MAN_W:0]   div_result,
  output logic                   result_ready,
  input  logic                   result_accept,
  output logic                   flag_dz,
  output logic                   flag_inv,
  output logic                   flag_ovf,
  output logic                   flag_unf
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int QBITS = MAN_W + 3;
  localparam int CW = $clog2(QBITS + 1);
  localparam logic signed [EXP_W+1:0] BIAS_E = {3'b0, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W+1:0] ONE = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] MAXE = {2'b0, {EXP_W{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] a, b;
  logic [QBITS-1:0] q;
  logic [MAN_W+1:0] r;
  logic [MAN_W:0] mb;
  logic signed [EXP_W+1:0] e, en, ef;
  logic [CW-1:0] cnt;
  logic sgn, za, zb, ia, ib, na, nb, spec, nan_c, inv_c, dz_c, inf_c, ge;
  logic hi, g, s, inc, ovf, unf;
  logic [MAN_W-1:0] frac_pre, frac;
  logic [W-1:0] spec_res, rnd_res;
  assign sgn = a[W-1] ^ b[W-1];
  assign za = a[W-2:MAN_W] == '0;
  assign zb = b[W-2:MAN_W] == '0;
  assign ia = &a[W-2:MAN_W] & ~|a[MAN_W-1:0];
  assign ib = &b[W-2:MAN_W] & ~|b[MAN_W-1:0];
  assign na = &a[W-2:MAN_W] & |a[MAN_W-1:0];
  assign nb = &b[W-2:MAN_W] & |b[MAN_W-1:0];
  assign spec = za | zb | (&a[W-2:MAN_W]) | (&b[W-2:MAN_W]);
  assign nan_c = na | nb;
  assign inv_c = ~nan_c & ((za & zb) | (ia & ib));
  assign dz_c = ~nan_c & zb & ~za & ~ia;
  assign inf_c = dz_c | (~nan_c & ia & ~ib);
  assign spec_res = (nan_c | inv_c) ? QNAN :
                    inf_c ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn, {(W-1){1'b0}}};
  assign ge = r >= {1'b0, mb};
  assign div_ready = state == IDLE;
  assign result_ready = state == DONE;
  // The hidden bit is implicitly 1, so a carry out of the fraction lands
  // directly in the exponent: mantissa becomes 1.0 and e increments.
  always_comb begin
    hi = q[QBITS-1];
    frac_pre = hi ? q[QBITS-2:2] : q[QBITS-3:1];
    g = hi ? q[1] : q[0];
    s = (hi & q[0]) | (|r);
    en = hi ? e : e - ONE;
    inc = g & (s | frac_pre[0]);
    {ef, frac} = {en, frac_pre} + (EXP_W+2+MAN_W)'(inc);
    ovf = ef >= MAXE;
    unf = ef < ONE;
    rnd_res = ovf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
              unf ? {sgn, {(W-1){1'b0}}} : {sgn, ef[EXP_W-1:0], frac};
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = div_start ? UNPACK : IDLE;
      UNPACK:  state_nx = spec ? ROUND : DIVIDE;
      DIVIDE:  state_nx = (cnt == CW'(QBITS-1)) ? ROUND : DIVIDE;
      ROUND:   state_nx = DONE;
      DONE:    state_nx = result_accept ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      q <= '0;
      r <= '0;
      mb <= '0;
      e <= '0;
      cnt <= '0;
      div_result <= '0;
      {flag_dz, flag_inv, flag_ovf, flag_unf} <= '0;
    end else begin
      case (state)
        IDLE: if (div_start) begin
          a <= dividend;
          b <= divisor;
          {flag_dz, flag_inv, flag_ovf, flag_unf} <= '0;
        end
        UNPACK: begin
          r <= {2'b01, a[MAN_W-1:0]};
          mb <= {1'b1, b[MAN_W-1:0]};
          q <= '0;
          cnt <= '0;
          e <= $signed({2'b0, a[W-2:MAN_W]}) - $signed({2'b0, b[W-2:MAN_W]}) + BIAS_E;
          if (spec) begin
            div_result <= spec_res;
            flag_inv <= inv_c;
            flag_dz <= dz_c;
          end
        end
        DIVIDE: begin
          r <= (ge ? r - {1'b0, mb} : r) << 1;
          q <= {q[QBITS-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        ROUND: if (!spec) begin
          div_result <= rnd_res;
          flag_ovf <= ovf;
          flag_unf <= unf;
        end
        default: ;
      endcase
    end
  end
endmodule
